canbus_tx_sched: RTL and testbench

CANBUS_TX_SCHED -- requirements
Module: canbus_tx_sched

---
 rtl/canbus_pkg.sv | 26 ++
 rtl/canbus_tx_sched_if.sv | 29 ++
 rtl/canbus_rr_arbiter.sv | 35 +++
 rtl/canbus_tx_sched.sv | 151 +++++++++++++++
 tb/tb_canbus_tx_sched.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/canbus_pkg.sv
// Shared CAN bus definitions used by the transmit scheduler and its companions:
// field widths, scheduler state encoding and default timing parameters.
package canbus_pkg;

    localparam int ID_W   = 11;
    localparam int DATA_W = 32;

    localparam int DEF_MAX_RETRY = 3;
    localparam int DEF_TIMEOUT   = 200000;
    localparam int DEF_GAP       = 64;

    localparam logic [7:0] ERR_SAT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } tx_state_t;

    // Channel index that follows idx in a ring of n channels.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/canbus_tx_sched_if.sv
// Requester-channel and frame-transmitter signals of the CAN transmit scheduler.
// The master modport is the scheduler; the slave modport is the requesters/transmitter.
interface canbus_tx_sched_if #(
    parameter int NUM_CH = 4
);

    logic [NUM_CH-1:0]                    ch_req;
    logic [NUM_CH*canbus_pkg::ID_W-1:0]   ch_id;
    logic [NUM_CH*canbus_pkg::DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]                    ch_ack;
    logic [NUM_CH-1:0]                    ch_err;

    logic                                 frm_start;
    logic [canbus_pkg::ID_W-1:0]          frm_id;
    logic [canbus_pkg::DATA_W-1:0]        frm_data;
    logic                                 frm_done;
    logic                                 frm_nack;

    modport master (
        input  ch_req, ch_id, ch_data, frm_done, frm_nack,
        output ch_ack, ch_err, frm_start, frm_id, frm_data
    );

    modport slave (
        output ch_req, ch_id, ch_data, frm_done, frm_nack,
        input  ch_ack, ch_err, frm_start, frm_id, frm_data
    );

endinterface

// File: rtl/canbus_rr_arbiter.sv
// Combinational round-robin arbiter: starting at ptr and wrapping around,
// the first channel with req high wins.
module canbus_rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  grant,
    output logic              valid
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] pos;

    // NOTE: every output gets a default before the loop so no path leaves a latch.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        pos   = '0;
        // Walk from the farthest offset back to ptr so the closest requester is written last.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + SUM_W'(i);
            if (pos >= SUM_W'(NUM_CH)) begin
                pos = pos - SUM_W'(NUM_CH);
            end
            if (req[pos[IDX_W-1:0]]) begin
                grant = pos[IDX_W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/canbus_tx_sched.sv
// CAN transmit scheduler: grants requester channels round-robin, issues one frame at a
// time to the transmitter, retries on NACK, drops on retry exhaustion or timeout.
module canbus_tx_sched
    import canbus_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int MAX_RETRY = DEF_MAX_RETRY,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int GAP       = DEF_GAP
) (
    input  logic                     clk,
    input  logic                     rst,
    canbus_tx_sched_if.master        bus,
    output logic                     busy,
    output logic [7:0]               err_count
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    tx_state_t          state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant;
    logic [RTY_W-1:0]   retry_cnt;
    logic               retry_pend;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [IDX_W-1:0]   arb_grant;
    logic               arb_valid;
    logic [ID_W-1:0]    sel_id;
    logic [DATA_W-1:0]  sel_data;
    logic [IDX_W-1:0]   next_ptr;

    canbus_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req   (bus.ch_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        sel_id   = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (arb_grant == IDX_W'(k)) begin
                sel_id   = bus.ch_id[k*ID_W +: ID_W];
                sel_data = bus.ch_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr = IDX_W'(wrap_inc(int'(grant), NUM_CH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            grant         <= '0;
            retry_cnt     <= '0;
            retry_pend    <= 1'b0;
            tmo_cnt       <= '0;
            gap_cnt       <= '0;
            err_count     <= '0;
            busy          <= 1'b0;
            bus.frm_start <= 1'b0;
            bus.ch_ack    <= '0;
            bus.ch_err    <= '0;
            bus.frm_id    <= '0;
            bus.frm_data  <= '0;
        end else begin
            // NOTE: pulse outputs default low each cycle; only the branch that fires raises them.
            bus.frm_start <= 1'b0;
            bus.ch_ack    <= '0;
            bus.ch_err    <= '0;

            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant        <= arb_grant;
                        bus.frm_id   <= sel_id;
                        bus.frm_data <= sel_data;
                        retry_cnt    <= '0;
                        retry_pend   <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    bus.frm_start <= 1'b1;
                    tmo_cnt       <= '0;
                    state         <= ST_WAIT_DONE;
                end

                ST_WAIT_DONE: begin
                    // Done wins over a simultaneous NACK.
                    if (bus.frm_done) begin
                        bus.ch_ack[grant] <= 1'b1;
                        rr_ptr            <= next_ptr;
                        retry_pend        <= 1'b0;
                        gap_cnt           <= '0;
                        state             <= ST_GAP;
                    end else if (bus.frm_nack && (retry_cnt < RTY_W'(MAX_RETRY))) begin
                        retry_cnt  <= retry_cnt + 1'b1;
                        retry_pend <= 1'b1;
                        gap_cnt    <= '0;
                        state      <= ST_GAP;
                    end else if (bus.frm_nack || (tmo_cnt == TMO_W'(TIMEOUT - 1))) begin
                        bus.ch_ack[grant] <= 1'b1;
                        bus.ch_err[grant] <= 1'b1;
                        if (err_count != ERR_SAT) begin
                            err_count <= err_count + 8'd1;
                        end
                        rr_ptr     <= next_ptr;
                        retry_pend <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP - 1)) begin
                        if (retry_pend) begin
                            retry_pend <= 1'b0;
                            state      <= ST_ISSUE;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    retry_pend <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_canbus_tx_sched.sv
// Self-checking bench for canbus_tx_sched: directed scenarios plus randomized frames
// compared against a transaction-level model of grant order, outcomes and error count.
`timescale 1ns/1ps
module tb_canbus_tx_sched;
    import canbus_pkg::*;

    localparam int NUM_CH    = 4;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 100;
    localparam int GAP       = 8;
    localparam int BUDGET    = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] err_count;

    canbus_tx_sched_if #(.NUM_CH(NUM_CH)) bus();

    canbus_tx_sched #(
        .NUM_CH    (NUM_CH),
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT),
        .GAP       (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    logic [ID_W-1:0]   tb_id   [NUM_CH];
    logic [DATA_W-1:0] tb_data [NUM_CH];

    always_comb begin
        bus.ch_id   = '0;
        bus.ch_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            bus.ch_id[k*ID_W +: ID_W]       = tb_id[k];
            bus.ch_data[k*DATA_W +: DATA_W] = tb_data[k];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;
    int last_start = -1000;

    // Reference model state: round-robin pointer and dropped-frame count.
    int m_rr = 0;
    int m_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_grant(input logic [NUM_CH-1:0] req, input int rr);
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[(rr + i) % NUM_CH]) return (rr + i) % NUM_CH;
        end
        return 0;
    endfunction

    task automatic new_vals(input int k);
        tb_id[k]   = ID_W'(($urandom_range(1, 511) << 2) | k);
        tb_data[k] = $urandom;
    endtask

    task automatic wait_start(output bit ok);
        int n;
        n = 0;
        while (bus.frm_start !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        ok = (bus.frm_start === 1'b1);
        chk("frm_start_seen", ok, 1);
        if (!ok) finish_run();
        chk("start_spacing", (cyc - last_start) >= GAP + 2, 1);
        last_start = cyc;
    endtask

    // One complete frame: nacks NACKs first, then fin (0 done, 1 done+nack, 2 silence).
    task automatic do_frame(input int nacks, input int fin, input int dly,
                            input logic [NUM_CH-1:0] next_req);
        int                exp_ch;
        logic [ID_W-1:0]   exp_id;
        logic [DATA_W-1:0] exp_data;
        bit                ok;
        bit                drop;
        exp_ch   = model_grant(bus.ch_req, m_rr);
        exp_id   = tb_id[exp_ch];
        exp_data = tb_data[exp_ch];
        drop     = (nacks > MAX_RETRY) || (fin == 2);
        for (int a = 0; a <= nacks && a <= MAX_RETRY; a++) begin
            wait_start(ok);
            chk("frm_id", bus.frm_id, exp_id);
            chk("frm_data", bus.frm_data, exp_data);
            if (a == 0) begin
                new_vals(exp_ch);
                bus.ch_req = next_req;
            end
            if (a < nacks) begin
                repeat (dly) begin
                    tick();
                    chk("start_one_cycle", bus.frm_start, 0);
                    chk("no_ack_waiting", bus.ch_ack, 0);
                end
                bus.frm_nack = 1'b1;
                tick();
                bus.frm_nack = 1'b0;
                if (a < MAX_RETRY) chk("no_ack_on_retry", bus.ch_ack, 0);
            end else if (fin == 2) begin
                repeat (TIMEOUT - 1) tick();
                chk("no_ack_before_timeout", bus.ch_ack, 0);
                tick();
            end else begin
                repeat (dly) begin
                    tick();
                    chk("start_one_cycle", bus.frm_start, 0);
                    chk("no_ack_waiting", bus.ch_ack, 0);
                end
                bus.frm_done = 1'b1;
                bus.frm_nack = (fin == 1);
                tick();
                bus.frm_done = 1'b0;
                bus.frm_nack = 1'b0;
            end
        end
        m_rr = (exp_ch + 1) % NUM_CH;
        if (drop && m_err < 255) m_err++;
        chk("ch_ack", bus.ch_ack, 64'(1) << exp_ch);
        chk("ch_err", bus.ch_err, drop ? (64'(1) << exp_ch) : 64'(0));
        chk("err_count", err_count, 64'(m_err));
        chk("busy_in_gap", busy, 1);
        tick();
        chk("ack_single_pulse", bus.ch_ack, 0);
        chk("err_single_pulse", bus.ch_err, 0);
    endtask

    initial begin
        bit ok;
        bus.ch_req   = '0;
        bus.frm_done = 1'b0;
        bus.frm_nack = 1'b0;
        tb_id[0] = 11'h100; tb_data[0] = 32'hA000_0000;
        tb_id[1] = 11'h201; tb_data[1] = 32'hB000_0001;
        tb_id[2] = 11'h00D; tb_data[2] = 32'h1234_5678;
        tb_id[3] = 11'h303; tb_data[3] = 32'hC000_0003;

        // Reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_start", bus.frm_start, 0);
        chk("rst_ack", bus.ch_ack, 0);
        chk("rst_err", bus.ch_err, 0);
        chk("rst_frm_id", bus.frm_id, 0);
        chk("rst_frm_data", bus.frm_data, 0);
        chk("rst_err_count", err_count, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Done/NACK while idle are ignored
        bus.frm_done = 1'b1;
        bus.frm_nack = 1'b1;
        tick();
        bus.frm_done = 1'b0;
        bus.frm_nack = 1'b0;
        tick();
        chk("idle_done_no_ack", bus.ch_ack, 0);
        chk("idle_nack_no_err", err_count, 0);
        chk("idle_not_busy", busy, 0);

        // Single requester: two-cycle latency, latched fields, done after 10 cycles
        bus.ch_req = 4'b0100;
        tick();
        chk("latency_c1_start", bus.frm_start, 0);
        chk("latency_c1_busy", busy, 1);
        tick();
        chk("latency_c2_start", bus.frm_start, 1);
        chk("single_frm_id", bus.frm_id, 11'h00D);
        chk("single_frm_data", bus.frm_data, 32'h1234_5678);
        do_frame(0, 0, 10, 4'b1111);

        // Reset during WAIT_DONE: outputs clear immediately, no ack, pointer restarts at 0
        wait_start(ok);
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_frm_id", bus.frm_id, 0);
        chk("midrst_frm_data", bus.frm_data, 0);
        chk("midrst_start", bus.frm_start, 0);
        chk("midrst_ack", bus.ch_ack, 0);
        chk("midrst_err", bus.ch_err, 0);
        repeat (3) begin
            tick();
            chk("midrst_hold_ack", bus.ch_ack, 0);
        end
        rst = 1'b0;
        m_rr = 0;
        last_start = -1000;

        // All channels requesting: order 0,1,2,3,0
        for (int f = 0; f < 5; f++) begin
            do_frame(0, 0, $urandom_range(0, 4), (f == 4) ? 4'b0010 : 4'b1111);
        end

        // Channel 1 NACKed on every attempt: four issues, then drop
        do_frame(MAX_RETRY + 1, 0, 0, 4'b0001);
        chk("nack_drop_err_count", err_count, 1);

        // Silent transmitter: timeout drop, then busy falls after the gap
        do_frame(0, 2, 0, 4'b0000);
        repeat (GAP - 2) tick();
        chk("timeout_busy_before_gap_end", busy, 1);
        tick();
        chk("timeout_busy_after_gap", busy, 0);

        // Randomized frames
        bus.ch_req = 4'($urandom_range(1, 15));
        for (int f = 0; f < 40; f++) begin
            do_frame($urandom_range(0, MAX_RETRY + 1),
                     ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1)),
                     $urandom_range(0, 4),
                     4'($urandom_range(1, 15)));
        end

        // 300 forced drops saturate the error counter
        for (int f = 0; f < 300; f++) begin
            do_frame(MAX_RETRY + 1, 0, 0, 4'($urandom_range(1, 15)));
        end
        chk("err_count_saturated", err_count, 255);

        // Simultaneous done and NACK count as success
        do_frame(0, 1, 2, 4'b0000);
        chk("both_keeps_err_count", err_count, 255);
        repeat (GAP + 2) tick();
        chk("final_idle", busy, 0);

        finish_run();
    end

endmodule
